// File: rtl/full_adder.sv
// One-bit full adder, the cell replicated across the multiplier's reduction array.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/comb_multiplier_8.sv
// Unsigned 8x8 array multiplier: AND partial products, carry-save rows, final ripple add,
// product zero-extended to 32 bits and registered once.
module comb_multiplier_8 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  lop,
    input  logic [7:0]  rop,
    output logic [31:0] oval
);

    localparam int OP_W   = 8;
    localparam int PROD_W = 2 * OP_W;
    localparam int RES_W  = 32;

    logic [PROD_W-1:0] ppRow [OP_W];
    logic [PROD_W-1:0] product;

    // Row i holds lop gated by rop[i], already shifted into its weight position.
    always_comb begin
        for (int i = 0; i < OP_W; i++) begin
            ppRow[i] = PROD_W'({OP_W{rop[i]}} & lop) << i;
        end
    end

    // Carry-save accumulation: each row folds one partial product into a (sum, carry) pair.
    // The top bit never needs a carry out because the true product fits in 16 bits.
    for (genvar i = 0; i < OP_W; i++) begin : row
        logic [PROD_W-1:0] s;
        logic [PROD_W-1:0] c;
        if (i == 0) begin : g_first
            assign s = ppRow[0];
            assign c = '0;
        end else begin : g_csa
            logic [PROD_W-2:0] co;
            for (genvar b = 0; b < PROD_W - 1; b++) begin : bitc
                full_adder u_fa (
                    .a   (row[i-1].s[b]),
                    .b   (row[i-1].c[b]),
                    .cin (ppRow[i][b]),
                    .s   (s[b]),
                    .cout(co[b])
                );
            end
            assign s[PROD_W-1] = row[i-1].s[PROD_W-1] ^ row[i-1].c[PROD_W-1] ^ ppRow[i][PROD_W-1];
            assign c = {co, 1'b0};
        end
    end

    // Final carry-propagate adder resolves the last sum/carry pair into the product.
    for (genvar b = 0; b < PROD_W - 1; b++) begin : rip
        logic ci;
        logic co;
        if (b == 0) begin : g_cin0
            assign ci = 1'b0;
        end else begin : g_cin
            assign ci = rip[b-1].co;
        end
        full_adder u_fa (
            .a   (row[OP_W-1].s[b]),
            .b   (row[OP_W-1].c[b]),
            .cin (ci),
            .s   (product[b]),
            .cout(co)
        );
    end

    assign product[PROD_W-1] = row[OP_W-1].s[PROD_W-1] ^ row[OP_W-1].c[PROD_W-1]
                             ^ rip[PROD_W-2].co;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oval <= '0;
        end else begin
            oval <= {{(RES_W - PROD_W){1'b0}}, product};
        end
    end

endmodule

// File: tb/tb_comb_multiplier_8.sv
// Self-checking bench for comb_multiplier_8 against an arithmetic reference model.
module tb_comb_multiplier_8;

    logic        clk;
    logic        reset_n;
    logic [7:0]  lop;
    logic [7:0]  rop;
    logic [31:0] oval;

    int checks;
    int errors;

    comb_multiplier_8 dut (
        .clk    (clk),
        .reset_n(reset_n),
        .lop    (lop),
        .rop    (rop),
        .oval   (oval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] refProduct(input logic [7:0] a, input logic [7:0] b);
        int unsigned prod;
        prod = int'(a) * int'(b);
        return 32'(prod);
    endfunction

    // Operands change on the falling edge, away from the capturing edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        lop = a;
        rop = b;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        lop = 8'd5;
        rop = 8'd3;
        #3;
        checks++;
        if (oval !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_immediate: oval=%0d expected=0", oval);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (oval !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_held: oval=%0d expected=0", oval);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (oval !== 32'd15) begin
            errors++;
            $display("[TB] FAIL reset_release: oval=%0d expected=15", oval);
        end
    endtask

    task automatic test_hold();
        applyStimulus(8'd45, 8'd13);
        #1;
        checks++;
        if (oval !== 32'd15) begin
            errors++;
            $display("[TB] FAIL hold_before_edge: oval=%0d expected=15", oval);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (oval !== 32'd585) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: oval=%0d expected=585", k, oval);
            end
        end
    endtask

    task automatic test_corners();
        logic [7:0] aList [6] = '{8'd20, 8'd0, 8'd1, 8'd255, 8'd255, 8'd128};
        logic [7:0] bList [6] = '{8'd5, 8'd77, 8'd200, 8'd1, 8'd255, 8'd2};
        logic [31:0] expv;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(aList[k], bList[k]);
            expv = refProduct(aList[k], bList[k]);
            @(posedge clk);
            #1;
            checks++;
            if (oval !== expv) begin
                errors++;
                $display("[TB] FAIL corner %0dx%0d: oval=%0d expected=%0d",
                         aList[k], bList[k], oval, expv);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  aList [4] = '{8'd1, 8'd2, 8'd17, 8'd255};
        logic [7:0]  bList [4] = '{8'd1, 8'd3, 8'd15, 8'd254};
        logic [31:0] expList [4] = '{32'd1, 32'd6, 32'd255, 32'd64770};
        for (int k = 0; k < 4; k++) begin
            applyStimulus(aList[k], bList[k]);
            @(posedge clk);
            #1;
            checks++;
            if (oval !== expList[k]) begin
                errors++;
                $display("[TB] FAIL b2b_%0d: oval=%0d expected=%0d", k, oval, expList[k]);
            end
        end
        applyStimulus(8'd9, 8'd11);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (oval !== 32'd0) begin
            errors++;
            $display("[TB] FAIL b2b_midreset: oval=%0d expected=0", oval);
        end
        @(posedge clk);
        #1;
        checks++;
        if (oval !== 32'd0) begin
            errors++;
            $display("[TB] FAIL b2b_reset_edge: oval=%0d expected=0", oval);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (oval !== 32'd99) begin
            errors++;
            $display("[TB] FAIL b2b_resume: oval=%0d expected=99", oval);
        end
    endtask

    task automatic test_random();
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] expv;
        for (int k = 0; k < 500; k++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            applyStimulus(a, b);
            expv = refProduct(a, b);
            @(posedge clk);
            #1;
            checks++;
            if (oval !== expv) begin
                errors++;
                if (errors < 20)
                    $display("[TB] FAIL random %0dx%0d: oval=%0d expected=%0d", a, b, oval, expv);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [31:0] expv;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                applyStimulus(8'(a), 8'(b));
                expv = refProduct(8'(a), 8'(b));
                @(posedge clk);
                #1;
                checks++;
                if (oval !== expv) begin
                    errors++;
                    if (errors < 20)
                        $display("[TB] FAIL sweep %0dx%0d: oval=%0d expected=%0d", a, b, oval, expv);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_hold();
        test_corners();
        test_back_to_back();
        test_random();
        test_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
